// File: rtl/hamming_scrubber.sv
// hamming_scrubber: walks a Hamming(15,11) codeword RAM, re-checks each word
// and writes back the corrected re-encoding whenever it differs from the stored
// word. One pass covers addresses 0..2**AW-1 in ascending order.
//
// Ports:
//   clk, rst_n  - single clock, asynchronous active-low reset
//   start       - level, sampled only while idle; high starts a pass
//   busy        - high in every state except idle
//   done        - one-cycle pulse at the end of a pass
//   mem_addr    - RAM address (driven in read and write-back cycles, else 0)
//   mem_re      - RAM read enable, data returns on mem_rdata next cycle
//   mem_rdata   - RAM read data
//   mem_we      - RAM write enable
//   mem_wdata   - RAM write data (corrected codeword)
//   corr_count  - words rewritten in the current/last pass, saturating
//
// Codeword layout (shared by calcula_hamming and corrige_hamming): bit i holds
// Hamming position i+1. Parity sits at positions 1,2,4,8 (bits 0,1,3,7); data
// bits 0..10 fill bits 2,4,5,6,8..14 in order.

// calcula_hamming: encodes 11 data bits into a 15-bit codeword.
//   data - 11-bit payload
//   code - 15-bit codeword
module calcula_hamming (
   input  logic [10:0] data,
   output logic [14:0] code
);

   logic [14:0] placed;
   logic [3:0]  syn;

   always_comb begin
      placed        = '0;
      placed[2]     = data[0];
      placed[6:4]   = data[3:1];
      placed[14:8]  = data[10:4];
      // Syndrome of the data-only word gives exactly the parity bits needed
      // to drive the full syndrome to zero.
      syn = '0;
      for (int i = 0; i < 15; i++) begin
         if (placed[i]) syn = syn ^ 4'(i + 1);
      end
      code    = placed;
      code[0] = syn[0];
      code[1] = syn[1];
      code[3] = syn[2];
      code[7] = syn[3];
   end

endmodule

// corrige_hamming: corrects up to one flipped bit and returns the data bits.
//   code - 15-bit received codeword
//   data - 11-bit corrected payload
module corrige_hamming (
   input  logic [14:0] code,
   output logic [10:0] data
);

   logic [3:0]  syn;
   logic [14:0] fixed;

   always_comb begin
      syn = '0;
      for (int i = 0; i < 15; i++) begin
         if (code[i]) syn = syn ^ 4'(i + 1);
      end
      // A non-zero syndrome is the 1-based position of the bit to flip.
      fixed = code;
      if (syn != 4'd0) fixed = code ^ (15'(1) << (syn - 4'd1));
   end

   assign data = {fixed[14:8], fixed[6:4], fixed[2]};

endmodule

module hamming_scrubber #(
   parameter int unsigned AW = 4,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   input  logic [14:0]   mem_rdata,
   output logic          mem_we,
   output logic [14:0]   mem_wdata,
   output logic [CW-1:0] corr_count
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWt,
      StCk,
      StWb,
      StNx,
      StDone
   } state_t;

   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic [14:0]   cw_q;
   logic [10:0]   dec_data;
   logic [14:0]   fix;

   corrige_hamming u_corrige (
      .code (cw_q),
      .data (dec_data)
   );

   calcula_hamming u_calcula (
      .data (dec_data),
      .code (fix)
   );

   // Outputs are registered alongside the state: each transition loads the
   // output values belonging to the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cw_q       <= '0;
         corr_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_addr   <= '0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
      end else begin
         busy      <= 1'b1;
         done      <= 1'b0;
         mem_addr  <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  corr_count <= '0;
                  addr_q     <= '0;
                  mem_re     <= 1'b1;
                  state_q    <= StRd;
               end else begin
                  busy <= 1'b0;
               end
            end
            StRd: begin
               state_q <= StWt;
            end
            StWt: begin
               cw_q    <= mem_rdata;
               state_q <= StCk;
            end
            StCk: begin
               if (fix != cw_q) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= fix;
                  state_q   <= StWb;
               end else begin
                  state_q <= StNx;
               end
            end
            StWb: begin
               if (corr_count != {CW{1'b1}}) corr_count <= corr_count + CW'(1);
               state_q <= StNx;
            end
            StNx: begin
               if (addr_q == {AW{1'b1}}) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  addr_q   <= addr_q + AW'(1);
                  mem_addr <= addr_q + AW'(1);
                  mem_re   <= 1'b1;
                  state_q  <= StRd;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
